// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit.
// It takes its operands from the register-file read ports and writes the result back
// through the write port with a one-cycle reg_write pulse. The multiply is shift-add and
// the divide is restoring; each takes Width iterations. A zero divisor skips the loop.
module mul_div_unit #(
  parameter int unsigned Width = 24,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [Width-1:0] read_rs_i,
  input  logic [Width-1:0] read_rt_i,
  input  logic [AddrW-1:0] rd_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             reg_write_o,
  output logic [AddrW-1:0] rd_o,
  output logic [Width-1:0] write_data_o
);

  localparam int unsigned CntW = $clog2(Width + 1);

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } state_e;

  localparam logic [1:0] OpMulLo = 2'b00;
  localparam logic [1:0] OpMulHi = 2'b01;
  localparam logic [1:0] OpDivQ  = 2'b10;
  localparam logic [1:0] OpDivR  = 2'b11;

  state_e               state_q;
  logic [1:0]           op_q;
  logic [CntW-1:0]      cnt_q;
  logic [Width-1:0]     opa_q;         // multiplicand
  logic [Width-1:0]     opb_q;         // divisor
  logic [2*Width-1:0]   prod_q;        // {partial sum, remaining multiplier bits}
  logic [Width-1:0]     rem_q;         // restored partial remainder
  logic [Width-1:0]     dq_q;          // dividend bits shift out, quotient bits shift in
  logic [AddrW-1:0]     rd_q;
  logic [AddrW-1:0]     rd_out_q;
  logic [Width-1:0]     write_data_q;
  logic                 busy_q;
  logic                 done_q;

  logic [Width:0]       mul_sum;
  logic [2*Width-1:0]   prod_step;
  logic [Width:0]       div_shift;
  logic [Width:0]       div_diff;
  logic                 div_ge;
  logic [Width-1:0]     rem_step;
  logic [Width-1:0]     dq_step;
  logic [Width-1:0]     result;

  // One iteration of each datapath, plus the result the unit would write if this were the
  // final iteration.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*Width-1:Width]} + (prod_q[0] ? {1'b0, opa_q} : '0);
    prod_step = {mul_sum, prod_q[Width-1:1]};

    div_shift = {rem_q, dq_q[Width-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    // div_shift < 2*divisor, so bit Width of the difference is a valid sign bit
    div_ge    = ~div_diff[Width];
    rem_step  = div_ge ? div_diff[Width-1:0] : div_shift[Width-1:0];
    dq_step   = {dq_q[Width-2:0], div_ge};

    result = '0;
    unique case (op_q)
      OpMulLo: result = prod_step[Width-1:0];
      OpMulHi: result = prod_step[2*Width-1:Width];
      OpDivQ:  result = dq_step;
      OpDivR:  result = rem_step;
      default: result = '0;
    endcase
  end

  // Control FSM, iteration registers and registered write-back outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      op_q         <= '0;
      cnt_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      prod_q       <= '0;
      rem_q        <= '0;
      dq_q         <= '0;
      rd_q         <= '0;
      rd_out_q     <= '0;
      write_data_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            op_q   <= op_i;
            opa_q  <= read_rs_i;
            opb_q  <= read_rt_i;
            rd_q   <= rd_in_i;
            cnt_q  <= CntW'(Width);
            prod_q <= {{Width{1'b0}}, read_rt_i};
            rem_q  <= '0;
            dq_q   <= read_rs_i;
            busy_q <= 1'b1;
            if (!op_i[1]) begin
              state_q <= StMul;
            end else if (read_rt_i != '0) begin
              state_q <= StDiv;
            end else begin
              // Divide by zero: quotient saturates, remainder is the dividend
              state_q      <= StDone;
              done_q       <= 1'b1;
              rd_out_q     <= rd_in_i;
              write_data_q <= op_i[0] ? read_rs_i : '1;
            end
          end
        end
        StMul: begin
          prod_q <= prod_step;
          cnt_q  <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q      <= StDone;
            done_q       <= 1'b1;
            rd_out_q     <= rd_q;
            write_data_q <= result;
          end
        end
        StDiv: begin
          rem_q <= rem_step;
          dq_q  <= dq_step;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q      <= StDone;
            done_q       <= 1'b1;
            rd_out_q     <= rd_q;
            write_data_q <= result;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign reg_write_o  = done_q;
  assign rd_o         = rd_out_q;
  assign write_data_o = write_data_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed results, latency, busy window,
// ignored starts, back-to-back issue and reset abort.
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [23:0] a;
  logic [23:0] b;
  logic [3:0]  rdin;
  logic        busy;
  logic        done;
  logic        reg_write;
  logic [3:0]  rd;
  logic [23:0] wd;

  int n_total = 0;
  int n_bad   = 0;

  mul_div_unit #(
    .Width(24),
    .AddrW(4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .op_i        (op),
    .read_rs_i   (a),
    .read_rt_i   (b),
    .rd_in_i     (rdin),
    .busy_o      (busy),
    .done_o      (done),
    .reg_write_o (reg_write),
    .rd_o        (rd),
    .write_data_o(wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the unit idle. Issues one request, optionally hammers start
  // with junk while busy (including the DONE cycle), and returns at the negedge of the
  // idle cycle right after Done so the next call issues back-to-back.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [23:0] x,
                        input logic [23:0] y, input logic [3:0] r, input logic [23:0] exp,
                        input int exp_lat, input bit intf);
    int          lat    = 0;
    int          busy_n = 0;
    int          pulses = 0;
    logic [23:0] got    = '0;
    logic [3:0]  got_rd = '0;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    rdin  = r;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_n++;
      if (reg_write) begin
        pulses++;
        lat    = n;
        got    = wd;
        got_rd = rd;
        check({tag, ".done_eq_rw"}, {31'd0, done}, 32'd1);
      end
      if (intf && n <= exp_lat) begin
        start = 1'b1;
        op    = o ^ 2'b01;
        a     = 24'h5A5A5A;
        b     = 24'h000003;
        rdin  = ~r;
      end
    end
    start = 1'b0;
    @(negedge clk);
    if (reg_write) pulses++;
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".busy_cycles"}, busy_n, exp_lat);
    check({tag, ".data"}, {8'd0, got}, {8'd0, exp});
    check({tag, ".rd"}, {28'd0, got_rd}, {28'd0, r});
    check({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".pulses"}, pulses, 1);
    check({tag, ".hold"}, {8'd0, wd}, {8'd0, exp});
  endtask

  initial begin
    int pulses;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    rdin  = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.rw", {31'd0, reg_write}, 32'd0);
    check("rst.rd", {28'd0, rd}, 32'd0);
    check("rst.wd", {8'd0, wd}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mullo_a", 2'b00, 24'h000123, 24'h000456, 4'd3, 24'h04EDC2, 25, 1'b0);
    run_op("mulhi_max", 2'b01, 24'hFFFFFF, 24'hFFFFFF, 4'd7, 24'hFFFFFE, 25, 1'b0);
    run_op("mullo_max", 2'b00, 24'hFFFFFF, 24'hFFFFFF, 4'd1, 24'h000001, 25, 1'b0);
    run_op("divq_intf", 2'b10, 24'd100, 24'd7, 4'd2, 24'h00000E, 25, 1'b1);
    run_op("divr_b2b", 2'b11, 24'd100, 24'd7, 4'd9, 24'h000002, 25, 1'b0);
    run_op("divq_zero", 2'b10, 24'h00ABCD, 24'h000000, 4'd4, 24'hFFFFFF, 1, 1'b0);
    run_op("divr_zero", 2'b11, 24'h00ABCD, 24'h000000, 4'd6, 24'h00ABCD, 1, 1'b1);
    run_op("mulhi_intf", 2'b01, 24'h800000, 24'h000004, 4'd12, 24'h000002, 25, 1'b1);

    // Abort a multiply at cycle 10
    start = 1'b1;
    op    = 2'b00;
    a     = 24'h000123;
    b     = 24'h000456;
    rdin  = 4'd5;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort.busy", {31'd0, busy}, 32'd0);
    check("abort.done", {31'd0, done}, 32'd0);
    check("abort.wd", {8'd0, wd}, 32'd0);
    check("abort.rd", {28'd0, rd}, 32'd0);
    rst    = 1'b0;
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (reg_write) pulses++;
    end
    check("abort.no_pulse", pulses, 0);

    // Reset and start on the same edge: nothing accepted
    rst   = 1'b1;
    start = 1'b1;
    op    = 2'b10;
    a     = 24'd100;
    b     = 24'd7;
    rdin  = 4'd8;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start.busy", {31'd0, busy}, 32'd0);
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (reg_write) pulses++;
    end
    check("rst_start.no_pulse", pulses, 0);

    // Still usable afterwards
    run_op("post_rst", 2'b11, 24'd1000, 24'd33, 4'd11, 24'd10, 25, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative 24-bit multiply/divide execution unit. It sits directly downstream of the register file and consumes the ReadRS/ReadRT operand pair.
- It returns its result through the register file write port, driving WriteData, RD and a one-cycle RegWrite pulse.
- Multi-cycle: it raises Busy so the control path stalls issue until the write-back cycle.

Parameters:
WIDTH, 24, operand/result width in bits; also the iteration count.
ADDR_W, 4, register address width (matches RS/RT/RD).

Ports:
Clock  input  1  rising-edge clock for all state.
Reset  input  1  synchronous, active-high reset.
Start  input  1  request; sampled only in IDLE.
Op  input  2  00 MULLO (low WIDTH bits of product), 01 MULHI (high WIDTH bits, unsigned), 10 DIVQ (unsigned quotient), 11 DIVR (unsigned remainder).
ReadRS  input  WIDTH  operand A (multiplicand / dividend).
ReadRT  input  WIDTH  operand B (multiplier / divisor).
RDIn  input  ADDR_W  destination register, captured with the operands.
Busy  output  1  high from the cycle after acceptance through the DONE cycle inclusive.
Done  output  1  one-cycle pulse in the DONE state.
RegWrite  output  1  equals Done; write enable to the register file.
RD  output  ADDR_W  captured destination; valid when Done.
WriteData  output  WIDTH  result; valid when Done, held until the next completion.

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset forces IDLE.
- Reset values: Busy=0, Done=0, RegWrite=0, RD=0, WriteData=0, counter=0, internal accumulators=0.
- Acceptance:
  - At a rising edge in IDLE with Start=1, latch ReadRS, ReadRT, RDIn and Op.
  - Load counter=WIDTH.
  - Op[1]=0 → MUL. Op[1]=1 with ReadRT≠0 → DIV. Op[1]=1 with ReadRT=0 → DONE directly.
- MUL: shift-add over a 2*WIDTH-bit product register.
  - Each cycle: if the multiplier LSB is set, add the multiplicand into the upper half; then shift the product right 1.
  - Counter decrements each cycle. On the edge where counter reaches 0, go to DONE.
- DIV: restoring division with a WIDTH+1-bit partial remainder.
  - Each cycle: shift {rem, dividend} left 1, then trial-subtract the divisor. If the result is non-negative, keep it and set the quotient LSB; otherwise restore.
  - Counter decrements each cycle; on reaching 0, go to DONE.
- Latency: acceptance at edge k → MUL/DIV occupies edges k+1..k+WIDTH → DONE is visible in the cycle after edge k+WIDTH. Done is high for exactly one cycle (WIDTH+1 cycles after acceptance).
- Divide by zero: DONE in the cycle after acceptance. DIVQ returns all ones (0xFFFFFF); DIVR returns the dividend.
- DONE state:
  - Done=RegWrite=1.
  - WriteData is selected by the latched Op (MULLO: product[WIDTH-1:0], MULHI: product[2W-1:W], DIVQ: quotient, DIVR: remainder).
  - RD is the latched RDIn.
  - The next edge returns to IDLE.
- WriteData and RD are registered, so they are stable throughout the Done cycle and hold afterwards.
- Start while Busy=1 (including the DONE cycle) is ignored, with no queuing. Start in the cycle after Done (IDLE) is accepted, giving back-to-back issue with one idle cycle between results.
- Operand inputs are not sampled after acceptance; changes on ReadRS/ReadRT/RDIn/Op while busy have no effect.
- Reset mid-operation: abandons the operation the next edge. No RegWrite pulse is produced, and all outputs return to their reset values.
- Reset and Start in the same edge: Reset wins and nothing is accepted.
- All arithmetic is unsigned. The product is exact (2*WIDTH bits); no overflow flag.

Test Plan:
- Reset, then MULLO with A=0x000123, B=0x000456, RDIn=3 → Busy high 25 cycles; Done/RegWrite pulse once at cycle 25 after acceptance; WriteData=0x04EDC2, RD=3.
- MULHI with A=B=0xFFFFFF, RDIn=7 → WriteData=0xFFFFFE. The same operands with MULLO → 0x000001.
- DIVQ 100/7 → WriteData=0x00000E. DIVR 100/7 → WriteData=0x000002, each with a 25-cycle latency.
- DIVQ 0x00ABCD/0 → Done in the cycle after acceptance, WriteData=0xFFFFFF. DIVR 0x00ABCD/0 → WriteData=0x00ABCD.
- Start pulses with different operands/RDIn during busy and during the DONE cycle → ignored; the result and RD match the first request; exactly one RegWrite pulse. A new Start in the following IDLE cycle is accepted.
- Reset asserted at cycle 10 of a MUL → next cycle Busy=0, WriteData=0, RD=0; no RegWrite pulse ever appears for the aborted operation.
